fp_normalize_iter: RTL and testbench

Parametrised, multi-cycle mantissa/exponent normaliser for the FP datapath, sitting between the add/sub mantissa stage and the rounding stage. It fully normalises in one transaction, using a bounded left shift per cycle or a single right shift on carry-out. It handles zero, denormal floor and exponent overflow, and reports them as flags. Valid/ready handshake on both sides, one transaction in flight.

---
 rtl/fp_normalize_iter_pkg.sv | 15 +
 rtl/fp_normalize_iter_if.sv | 30 +++
 rtl/fp_normalize_iter_lzc.sv | 28 ++
 rtl/fp_normalize_iter.sv | 147 ++++++++++++++
 tb/tb_fp_normalize_iter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_normalize_iter_pkg.sv
// Shared definitions for the FP mantissa/exponent normaliser: FSM state
// encoding and default geometry.
package fp_normalize_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_MANT_W     = 12;
  localparam int DEF_EXP_W      = 5;
  localparam int DEF_SHIFT_STEP = 4;

endpackage

// File: rtl/fp_normalize_iter_if.sv
// Valid/ready handshake bundle between the add/sub mantissa stage, the
// normaliser and the rounding stage.
interface fp_normalize_iter_if
  import fp_normalize_iter_pkg::*;
#(
  parameter int MANT_W = DEF_MANT_W,
  parameter int EXP_W  = DEF_EXP_W
);
  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] in_mant;
  logic [EXP_W-1:0]  in_exp;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] out_mant;
  logic [EXP_W-1:0]  out_exp;
  logic              out_zero;
  logic              out_ovf;
  logic              out_denorm;

  modport master (
    output in_valid, in_mant, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_zero, out_ovf, out_denorm
  );

  modport slave (
    input  in_valid, in_mant, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_zero, out_ovf, out_denorm
  );
endinterface

// File: rtl/fp_normalize_iter_lzc.sv
// Combinational leading-zero counter; counts from the MSB of data_i and
// flags an all-zero word (count saturates at W).
module fp_normalize_iter_lzc
  import fp_normalize_iter_pkg::*;
#(
  parameter int W    = DEF_MANT_W - 1,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     data_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic found;

  always_comb begin
    cnt_o  = CNT_W'(W);
    found  = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && data_i[i]) begin
        cnt_o = CNT_W'(W - 1 - i);
        found = 1'b1;
      end
    end
    zero_o = !found;
  end

endmodule

// File: rtl/fp_normalize_iter.sv
// Multi-cycle normaliser: one right shift on carry-out, otherwise bounded
// left shifts per cycle until the hidden bit is set or the exponent floors.
module fp_normalize_iter
  import fp_normalize_iter_pkg::*;
#(
  parameter int MANT_W     = DEF_MANT_W,
  parameter int EXP_W      = DEF_EXP_W,
  parameter int SHIFT_STEP = DEF_SHIFT_STEP
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_normalize_iter_if.slave  bus,
  output logic                busy_o
);

  localparam int LZ_W = $clog2(MANT_W);
  localparam int CAR  = MANT_W - 1;
  localparam int HID  = MANT_W - 2;
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam int unsigned STEP_U = SHIFT_STEP;

  state_t            state_q, state_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [MANT_W-1:0] omant_q;
  logic [EXP_W-1:0]  oexp_q;
  logic              ozero_q, oovf_q, oden_q;

  logic              accept, load_out;
  logic              zero_d, ovf_d, den_d;
  logic [LZ_W-1:0]   lz;
  logic              lz_zero;
  int unsigned       n_u;
  logic [MANT_W-1:0] mant_sh;
  logic [EXP_W-1:0]  exp_sh, exp_inc;

  // Leading zeros are counted below the carry bit, starting at the hidden bit.
  fp_normalize_iter_lzc #(
    .W     (MANT_W - 1),
    .CNT_W (LZ_W)
  ) u_lzc (
    .data_i (mant_q[HID:0]),
    .cnt_o  (lz),
    .zero_o (lz_zero)
  );

  always_comb begin
    n_u = 32'(lz);
    if (n_u > STEP_U) n_u = STEP_U;
    if (n_u > 32'(exp_q)) n_u = 32'(exp_q);
    mant_sh = mant_q << n_u;
    exp_sh  = exp_q - EXP_W'(n_u);
    exp_inc = exp_q + EXP_W'(1);
  end

  assign accept = (state_q == ST_IDLE) && bus.in_valid;

  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    load_out = 1'b0;
    zero_d   = 1'b0;
    ovf_d    = 1'b0;
    den_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mant_d  = bus.in_mant;
          exp_d   = bus.in_exp;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!mant_q[CAR] && lz_zero) begin
          exp_d    = '0;
          zero_d   = 1'b1;
          load_out = 1'b1;
        end else if (mant_q[CAR] && exp_q == EXP_MAX) begin
          ovf_d    = 1'b1;
          load_out = 1'b1;
        end else if (mant_q[CAR]) begin
          // Jam the shifted-out bit into bit 0 so rounding still sees it.
          mant_d   = {1'b0, mant_q[CAR:2], mant_q[1] | mant_q[0]};
          exp_d    = exp_inc;
          ovf_d    = (exp_inc == EXP_MAX);
          load_out = 1'b1;
        end else if (mant_q[HID]) begin
          load_out = 1'b1;
        end else if (exp_q == '0) begin
          den_d    = 1'b1;
          load_out = 1'b1;
        end else begin
          mant_d = mant_sh;
          exp_d  = exp_sh;
          if (mant_sh[HID] || exp_sh == '0) begin
            den_d    = !mant_sh[HID];
            load_out = 1'b1;
          end
        end
        if (load_out) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      omant_q <= '0;
      oexp_q  <= '0;
      ozero_q <= 1'b0;
      oovf_q  <= 1'b0;
      oden_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      if (load_out) begin
        omant_q <= mant_d;
        oexp_q  <= exp_d;
        ozero_q <= zero_d;
        oovf_q  <= ovf_d;
        oden_q  <= den_d;
      end else if (accept) begin
        ozero_q <= 1'b0;
        oovf_q  <= 1'b0;
        oden_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.out_mant   = omant_q;
  assign bus.out_exp    = oexp_q;
  assign bus.out_zero   = ozero_q;
  assign bus.out_ovf    = oovf_q;
  assign bus.out_denorm = oden_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fp_normalize_iter.sv
// Self-checking bench for fp_normalize_iter: directed cases, randomized
// transactions against an arithmetic reference, backpressure and reset.
module tb_fp_normalize_iter;
  localparam int MW   = 12;
  localparam int EW   = 5;
  localparam int STEP = 4;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_checks;
  int   n_fail;

  fp_normalize_iter_if #(.MANT_W(MW), .EXP_W(EW)) bus ();

  fp_normalize_iter #(.MANT_W(MW), .EXP_W(EW), .SHIFT_STEP(STEP)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: total left shift is the distance to the hidden bit, limited by the exponent.
  function automatic void model(input logic [MW-1:0] m, input logic [EW-1:0] e,
                                output logic [MW-1:0] rm, output logic [EW-1:0] re,
                                output logic [2:0] fl, output int cyc);
    int mi, ei, lz, tot;
    mi = int'(m);
    ei = int'(e);
    fl = 3'b000;
    cyc = 1;
    rm = m;
    re = e;
    if (mi == 0) begin
      rm = '0; re = '0; fl = 3'b100;
    end else if (mi >= (1 << (MW - 1))) begin
      if (ei == (1 << EW) - 1) begin
        fl = 3'b010;
      end else begin
        rm = MW'((mi / 2) | (mi % 2));
        re = EW'(ei + 1);
        if (ei + 1 == (1 << EW) - 1) fl = 3'b010;
      end
    end else if (mi < (1 << (MW - 2))) begin
      lz = 0;
      while ((mi << lz) < (1 << (MW - 2))) lz++;
      tot = (lz < ei) ? lz : ei;
      rm = MW'(mi << tot);
      re = EW'(ei - tot);
      if (tot < lz) fl = 3'b001;
      cyc = (tot == 0) ? 1 : (tot + STEP - 1) / STEP;
    end
  endfunction

  task automatic do_txn(input logic [MW-1:0] m, input logic [EW-1:0] e, input logic rdy,
                        output logic [MW-1:0] om, output logic [EW-1:0] oe,
                        output logic [2:0] fl, output int cyc, output logic tmo);
    @(negedge clk);
    bus.in_mant   = m;
    bus.in_exp    = e;
    bus.in_valid  = 1'b1;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    tmo = !bus.out_valid;
    om  = bus.out_mant;
    oe  = bus.out_exp;
    fl  = {bus.out_zero, bus.out_ovf, bus.out_denorm};
    if (rdy && !tmo) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [MW+EW+5:0] obs;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_mant = '0; bus.in_exp = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs = {bus.in_ready, bus.out_valid, busy, bus.out_mant, bus.out_exp,
           bus.out_zero, bus.out_ovf, bus.out_denorm};
    n_checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, {MW{1'b0}}, {EW{1'b0}}, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", obs,
               {1'b1, 1'b0, 1'b0, {MW{1'b0}}, {EW{1'b0}}, 3'b000});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [MW-1:0] tm [7] = '{12'h400, 12'h001, 12'h801, 12'h800, 12'h800, 12'h010, 12'h000};
    logic [EW-1:0] te [7] = '{5'd15, 5'd20, 5'd3, 5'd30, 5'd31, 5'd3, 5'd9};
    logic [MW-1:0] xm [7] = '{12'h400, 12'h400, 12'h401, 12'h400, 12'h800, 12'h080, 12'h000};
    logic [EW-1:0] xe [7] = '{5'd15, 5'd10, 5'd4, 5'd31, 5'd31, 5'd0, 5'd0};
    logic [2:0]    xf [7] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b001, 3'b100};
    int            xc [7] = '{1, 3, 1, 1, 1, 1, 1};
    logic [MW-1:0] om; logic [EW-1:0] oe; logic [2:0] fl; int cyc; logic tmo;
    for (int i = 0; i < 7; i++) begin
      do_txn(tm[i], te[i], 1'b1, om, oe, fl, cyc, tmo);
      n_checks++;
      if (tmo || {om, oe, fl} !== {xm[i], xe[i], xf[i]}) begin
        n_fail++;
        $display("FAIL directed_%0d result: got mant=%h exp=%0d flags=%b tmo=%b want mant=%h exp=%0d flags=%b",
                 i, om, oe, fl, tmo, xm[i], xe[i], xf[i]);
      end
      n_checks++;
      if (cyc !== xc[i]) begin
        n_fail++;
        $display("FAIL directed_%0d latency: got %0d want %0d", i, cyc, xc[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [MW-1:0] m, om, rm; logic [EW-1:0] e, oe, re; logic [2:0] fl, rf;
    int cyc, rc; logic tmo;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0:       m = '0;
        1:       m = MW'($urandom) | (MW'(1) << (MW - 1));
        default: m = MW'($urandom) & MW'((1 << $urandom_range(1, MW - 1)) - 1);
      endcase
      e = EW'($urandom);
      model(m, e, rm, re, rf, rc);
      do_txn(m, e, 1'b1, om, oe, fl, cyc, tmo);
      n_checks++;
      if (tmo || {om, oe, fl} !== {rm, re, rf}) begin
        n_fail++;
        $display("FAIL random_%0d in=%h/%0d: got mant=%h exp=%0d flags=%b want mant=%h exp=%0d flags=%b",
                 i, m, e, om, oe, fl, rm, re, rf);
      end
      n_checks++;
      if (cyc !== rc) begin
        n_fail++;
        $display("FAIL random_%0d latency in=%h/%0d: got %0d want %0d", i, m, e, cyc, rc);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [MW-1:0] om; logic [EW-1:0] oe; logic [2:0] fl; int cyc; logic tmo;
    logic [MW+EW+4:0] held, now;
    do_txn(12'h001, 5'd20, 1'b0, om, oe, fl, cyc, tmo);
    n_checks++;
    if (tmo || {om, oe, fl} !== {12'h400, 5'd10, 3'b000}) begin
      n_fail++;
      $display("FAIL backpressure_result: got mant=%h exp=%0d flags=%b want mant=400 exp=10 flags=000",
               om, oe, fl);
    end
    held = {1'b1, 1'b0, 12'h400, 5'd10, 3'b000};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_mant = 12'h801; bus.in_exp = 5'd7;
      @(posedge clk);
      #1;
      now = {bus.out_valid, bus.in_ready, bus.out_mant, bus.out_exp,
             bus.out_zero, bus.out_ovf, bus.out_denorm};
      n_checks++;
      if (now !== held) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d: got %h want %h", k, now, held);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL backpressure_release: got rdy/vld/busy=%b want 100",
               {bus.in_ready, bus.out_valid, busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [MW-1:0] tm [3] = '{12'h003, 12'h800, 12'h000};
    logic [EW-1:0] te [3] = '{5'd2, 5'd14, 5'd1};
    logic [MW-1:0] om, rm; logic [EW-1:0] oe, re; logic [2:0] fl, rf;
    int cyc, rc; logic tmo;
    for (int i = 0; i < 3; i++) begin
      model(tm[i], te[i], rm, re, rf, rc);
      do_txn(tm[i], te[i], 1'b1, om, oe, fl, cyc, tmo);
      n_checks++;
      if (tmo || {om, oe, fl, cyc} !== {rm, re, rf, rc}) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: got mant=%h exp=%0d flags=%b cyc=%0d want mant=%h exp=%0d flags=%b cyc=%0d",
                 i, om, oe, fl, cyc, rm, re, rf, rc);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [MW-1:0] om; logic [EW-1:0] oe; logic [2:0] fl; int cyc; logic tmo;
    logic [MW+EW+5:0] obs;
    @(negedge clk);
    bus.in_mant = 12'h001; bus.in_exp = 5'd20; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    obs = {bus.in_ready, bus.out_valid, busy, bus.out_mant, bus.out_exp,
           bus.out_zero, bus.out_ovf, bus.out_denorm};
    n_checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, {MW{1'b0}}, {EW{1'b0}}, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h want %h", obs,
               {1'b1, 1'b0, 1'b0, {MW{1'b0}}, {EW{1'b0}}, 3'b000});
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(12'h001, 5'd20, 1'b1, om, oe, fl, cyc, tmo);
    n_checks++;
    if (tmo || {om, oe, fl, cyc} !== {12'h400, 5'd10, 3'b000, 32'd3}) begin
      n_fail++;
      $display("FAIL reset_mid_recover: got mant=%h exp=%0d flags=%b cyc=%0d want mant=400 exp=10 flags=000 cyc=3",
               om, oe, fl, cyc);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
